// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, bounds and parity helper for the UART transmit path
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 8;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [DATA_W_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// rtl/uart_tx_fifo_param_if.sv - host write, frame config and status bundle of the UART transmitter
interface uart_tx_fifo_param_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              WR_EN;
  logic [DATA_W-1:0] WR_DATA;
  logic [DIV_W-1:0]  BAUD_DIV;
  logic [3:0]        START_BITS;
  logic [3:0]        STOP_BITS;
  logic              PARITY_EN;
  logic              PARITY_ODD;
  logic              UART_OUT;
  logic              FULL;
  logic              EMPTY;
  logic [LVL_W-1:0]  LEVEL;
  logic              BUSY;
  logic              OVERRUN;

  modport master (
    output WR_EN, WR_DATA, BAUD_DIV, START_BITS, STOP_BITS, PARITY_EN, PARITY_ODD,
    input  UART_OUT, FULL, EMPTY, LEVEL, BUSY, OVERRUN
  );

  modport slave (
    input  WR_EN, WR_DATA, BAUD_DIV, START_BITS, STOP_BITS, PARITY_EN, PARITY_ODD,
    output UART_OUT, FULL, EMPTY, LEVEL, BUSY, OVERRUN
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered status and sticky overrun
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic              overrun
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;
  logic              do_write;
  logic [LVL_W-1:0]  level_next;

  // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
  assign do_pop   = pop && !empty;
  assign do_write = wr_en && (!full || do_pop);
  assign rd_data  = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (do_write && !do_pop) begin
      level_next = level + 1'b1;
    end else if (!do_write && do_pop) begin
      level_next = level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_next;
      full  <= (level_next == LVL_W'(FIFO_DEPTH));
      empty <= (level_next == '0);
      if (wr_en && !do_write) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - buffered UART transmitter with per-frame start/stop/parity/baud config
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                 UART_CLK,
  input  logic                 RESET,
  uart_tx_fifo_param_if.slave  bus
);
  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("uart_tx_fifo_param: DATA_W must be within 5..8");
  end

  tx_state_t         state;
  tx_state_t         state_next;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_next;
  logic [DIV_W-1:0]  baud_cnt;
  logic [DIV_W-1:0]  baud_next;
  logic [DIV_W-1:0]  cfg_div;
  logic [3:0]        bit_cnt;
  logic [3:0]        bit_next;
  logic [3:0]        cfg_start;
  logic [3:0]        cfg_stop;
  logic              cfg_par_en;
  logic              par_bit;
  logic              pop;
  logic              tick;
  logic              out_next;
  logic              busy_next;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (UART_CLK),
    .rst     (RESET),
    .wr_en   (bus.WR_EN),
    .wr_data (bus.WR_DATA),
    .pop     (pop),
    .rd_data (head),
    .full    (bus.FULL),
    .empty   (bus.EMPTY),
    .level   (bus.LEVEL),
    .overrun (bus.OVERRUN)
  );

  assign tick = (baud_cnt == cfg_div);

  // UART_OUT is registered, so each branch computes the level of the bit being entered.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    out_next   = bus.UART_OUT;
    busy_next  = bus.BUSY;
    pop        = 1'b0;
    if (state == IDLE) begin
      out_next  = 1'b1;
      busy_next = 1'b0;
      if (!bus.EMPTY) begin
        pop        = 1'b1;
        state_next = START;
        out_next   = 1'b0;
        busy_next  = 1'b1;
        baud_next  = '0;
        bit_next   = '0;
      end
    end else if (!tick) begin
      baud_next = baud_cnt + 1'b1;
    end else begin
      baud_next = '0;
      bit_next  = bit_cnt + 1'b1;
      case (state)
        START: begin
          if (bit_cnt == cfg_start - 4'd1) begin
            state_next = DATA;
            bit_next   = '0;
            out_next   = shift[0];
          end
        end
        DATA: begin
          if (bit_cnt == LAST_DATA) begin
            bit_next = '0;
            if (cfg_par_en) begin
              state_next = PARITY;
              out_next   = par_bit;
            end else begin
              state_next = STOP;
              out_next   = 1'b1;
            end
          end else begin
            shift_next = shift >> 1;
            out_next   = shift[1];
          end
        end
        PARITY: begin
          state_next = STOP;
          bit_next   = '0;
          out_next   = 1'b1;
        end
        STOP: begin
          if (bit_cnt == cfg_stop - 4'd1) begin
            bit_next = '0;
            if (!bus.EMPTY) begin
              pop        = 1'b1;
              state_next = START;
              out_next   = 1'b0;
            end else begin
              state_next = IDLE;
              out_next   = 1'b1;
              busy_next  = 1'b0;
            end
          end
        end
        default: begin
          state_next = IDLE;
          out_next   = 1'b1;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge UART_CLK) begin
    if (RESET) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      cfg_div      <= '0;
      cfg_start    <= 4'd1;
      cfg_stop     <= 4'd1;
      cfg_par_en   <= 1'b0;
      par_bit      <= 1'b0;
      bus.UART_OUT <= 1'b1;
      bus.BUSY     <= 1'b0;
    end else begin
      state        <= state_next;
      baud_cnt     <= baud_next;
      bit_cnt      <= bit_next;
      bus.UART_OUT <= out_next;
      bus.BUSY     <= busy_next;
      if (pop) begin
        shift      <= head;
        cfg_div    <= bus.BAUD_DIV;
        cfg_start  <= (bus.START_BITS == 4'd0) ? 4'd1 : bus.START_BITS;
        cfg_stop   <= (bus.STOP_BITS == 4'd0) ? 4'd1 : bus.STOP_BITS;
        cfg_par_en <= bus.PARITY_EN;
        par_bit    <= calc_parity(DATA_W_MAX'(head), bus.PARITY_ODD);
      end else begin
        shift <= shift_next;
      end
    end
  end

endmodule
